err_watchdog: RTL
=================

// Module: err_watchdog
//
// PURPOSE
//  Synthesizable error source for the processor's err line. It sits between
//  the core's fault signals and the top-level err output that the clock/reset
//  generator samples.
//  - Merges the per-source fault strobes into one sticky err.
//  - Runs a no-retire watchdog, so a hung pipeline reports an error instead
//    of silently burning simulation cycles.
//  - Captures the first cause, the faulting source index and the cycle stamp
//    for debug.
//
// PARAMETERS
//  NUM_SRC  4     number of fault-strobe inputs; must be >= 2
//  SRC_W    2     width of err_src; equals clog2(NUM_SRC)
//  CNT_W    20    width of cycle_cnt and err_cycle; 2^CNT_W must be > 100004
//  TIMEOUT  1024  consecutive RUN cycles with no retire before a watchdog
//                 error; range 2 .. 2^CNT_W-1
//
// PORTS
//  clk        in   1        system clock; all state changes on its rising edge
//  rst        in   1        synchronous, active-high reset
//  src_err    in   NUM_SRC  per-source fault strobes: illegal op, misaligned
//                           access, etc.; sampled every cycle
//  retire     in   1        one instruction committed this cycle
//  halt       in   1        HALT instruction committed this cycle
//  err        out  1        sticky error flag; drives the top-level err
//  err_cause  out  2        00 none, 01 source fault, 10 watchdog, 11 unused
//  err_src    out  SRC_W    index of the captured faulting source
//                           (0 unless err_cause = 01)
//  err_cycle  out  CNT_W    cycle_cnt value in the cycle the error was detected
//  halted     out  1        core halted cleanly
//  cycle_cnt  out  CNT_W    cycles spent in RUN since reset
//
// BEHAVIOUR
//  - Reset
//    - rst=1 at a rising edge forces state=RUN and clears err, err_cause,
//      err_src, err_cycle, halted, cycle_cnt and idle_cnt.
//    - rst overrides every other input, including mid-error and mid-halt.
//  - All outputs are registered. Every detection is visible exactly 1 cycle
//    after the input cycle that caused it.
//  - FSM states
//    - RUN
//      - cycle_cnt += 1 each cycle, saturating at all-ones.
//      - idle_cnt is internal, CNT_W bits: 0 on a retire cycle, else += 1.
//    - Leaving RUN, evaluated in this priority order in the same cycle:
//      1. Any src_err bit = 1 -> ERROR.
//         - err_cause=01; err_src = lowest asserted index.
//         - Wins over a simultaneous halt or watchdog expiry.
//      2. retire=0 and idle_cnt == TIMEOUT-1 -> ERROR (watchdog).
//         - err_cause=10; err_src=0.
//      3. halt=1 -> HALTED; halted=1.
//         - halt with retire=1 in the same cycle is legal.
//      4. Otherwise stay in RUN.
//    - On either ERROR entry, err_cycle <= the cycle_cnt value of the
//      detecting cycle (before its increment).
//    - HALTED
//      - All counters freeze.
//      - src_err, retire and halt are ignored.
//      - Only rst leaves this state.
//    - ERROR
//      - err=1 is sticky.
//      - Counters and capture registers freeze.
//      - Later faults do not overwrite the first capture.
//      - Only rst leaves this state.
//  - Invariants
//    - err and halted are never both 1.
//    - err_cause == 00 iff err == 0.
//  - Watchdog expiry: TIMEOUT consecutive RUN cycles with retire=0, counted
//    from reset release or from the last retire, raise err on the next edge.
//    A retire in the expiry cycle itself cancels the expiry.
//
// TESTING (bench parameters: TIMEOUT=8, NUM_SRC=4)
//  1. Reset release; retire=1 for 20 cycles, then halt=1 for 1 cycle.
//     -> halted=1 one cycle later, err=0, cycle_cnt frozen at 21.
//  2. retire=0 from reset release.
//     -> err=1 after 8 cycles: err_cause=10, err_cycle=7, cycle_cnt=8.
//  3. retire=0 for 7 cycles, then retire=1 in cycle 7, then retire=0.
//     -> no error at cycle 8; watchdog fires with err_cycle=15.
//  4. In cycle 5, src_err=4'b1010 together with halt=1.
//     -> err=1, err_cause=01, err_src=1, err_cycle=5, halted=0.
//     -> src_err=4'b0001 in cycle 9 leaves the capture unchanged.
//  5. Watchdog expiry cycle coincides with src_err=4'b1000.
//     -> err_cause=01, err_src=3.
//  6. Assert rst for 1 cycle while in ERROR, and again while in HALTED.
//     -> all outputs 0 on the next edge; the scenario 2 timing repeats
//        exactly afterwards.

Source files
------------

// File: rtl/err_watchdog.sv
// err_watchdog: single sticky error source for the processor's err line.
//
// Merges per-source fault strobes into one sticky err, runs a no-retire
// watchdog so a hung pipeline reports an error, and captures the first
// cause, the faulting source index and the cycle stamp for debug.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   src_err    per-source fault strobes, sampled every cycle
//   retire     one instruction committed this cycle
//   halt       HALT instruction committed this cycle
//   err        sticky error flag
//   err_cause  00 none, 01 source fault, 10 watchdog
//   err_src    lowest asserted source index of the captured fault
//   err_cycle  cycle_cnt value in the detecting cycle
//   halted     core halted cleanly
//   cycle_cnt  cycles spent in RUN since reset (saturating)
module err_watchdog #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2,
    parameter int CNT_W   = 20,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_err,
    input  logic               retire,
    input  logic               halt,
    output logic               err,
    output logic [1:0]         err_cause,
    output logic [SRC_W-1:0]   err_src,
    output logic [CNT_W-1:0]   err_cycle,
    output logic               halted,
    output logic [CNT_W-1:0]   cycle_cnt
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HALTED = 2'd1,
        S_ERROR  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] idle_cnt;
    logic [SRC_W-1:0] low_idx;
    logic             any_src;
    logic             wdog_hit;

    // Lowest asserted source wins: scan high to low so the last hit sticks.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_err[i]) low_idx = SRC_W'(i);
        end
    end

    assign any_src  = |src_err;
    // idle_cnt holds the no-retire run length before this cycle, so hitting
    // TIMEOUT-1 with no retire now means TIMEOUT idle cycles in a row.
    assign wdog_hit = !retire && (idle_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= S_RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (any_src || wdog_hit) state_nxt = S_ERROR;
                else if (halt)           state_nxt = S_HALTED;
            end
            S_HALTED: state_nxt = S_HALTED;
            S_ERROR:  state_nxt = S_ERROR;
            default:  state_nxt = S_RUN;
        endcase
    end

    // Counters and capture only move while running; HALTED/ERROR freeze them.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            idle_cnt  <= '0;
            err_cause <= 2'b00;
            err_src   <= '0;
            err_cycle <= '0;
        end else if (state == S_RUN) begin
            if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
            idle_cnt <= retire ? '0 : idle_cnt + 1'b1;
            if (state_nxt == S_ERROR) begin
                err_cycle <= cycle_cnt;
                err_cause <= any_src ? 2'b01 : 2'b10;
                err_src   <= any_src ? low_idx : '0;
            end
        end
    end

    assign err    = (state == S_ERROR);
    assign halted = (state == S_HALTED);

endmodule
